// File: rtl/prog_loader_ctrl.sv
// Program loader: streams 32-bit words into processor memory one byte per cycle, then
// releases the processor and monitors for an exit ecall. Watchdog enabled by PROG_LOADER_TIMEOUT_EN.
module prog_loader_ctrl #(
    parameter int unsigned MEM_DEPTH      = 16384,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        word_valid,
    input  logic [31:0] word_data,
    input  logic        word_last,
    output logic        word_ready,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        cpu_reset,
    input  logic [31:0] gp,
    input  logic [31:0] a7,
    input  logic [31:0] a0,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic        load_err,
    output logic [31:0] result_code,
    output logic [31:0] cycle_count
);

`ifdef PROG_LOADER_TIMEOUT_EN
    localparam bit WDOG_EN = 1'b1;
`else
    localparam bit WDOG_EN = 1'b0;
`endif

    localparam logic [31:0] DEPTH_W      = 32'(MEM_DEPTH);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] EXIT_ECALL   = 32'd93;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_BOOT,
        S_RUN,
        S_FINISH
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] word_q, word_d;
    logic        last_q, last_d;
    logic [1:0]  byte_q, byte_d;
    logic        boot_q, boot_d;
    logic        load_err_q, load_err_d;
    logic [31:0] cycle_q, cycle_d;
    logic        pass_q, pass_d;
    logic        timeout_q, timeout_d;
    logic [31:0] result_q, result_d;

    logic [7:0]  cur_byte;
    logic        overflow;
    logic        exit_hit;
    logic        wdog_hit;

    assign cur_byte = word_q[{byte_q, 3'b000} +: 8];
    assign overflow = (addr_q >= DEPTH_W);
    assign exit_hit = (a7 == EXIT_ECALL);
    assign wdog_hit = WDOG_EN && (cycle_q == TIMEOUT_LAST);

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the same pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            word_q     <= '0;
            last_q     <= 1'b0;
            byte_q     <= '0;
            boot_q     <= 1'b0;
            load_err_q <= 1'b0;
            cycle_q    <= '0;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            word_q     <= word_d;
            last_q     <= last_d;
            byte_q     <= byte_d;
            boot_q     <= boot_d;
            load_err_q <= load_err_d;
            cycle_q    <= cycle_d;
            pass_q     <= pass_d;
            timeout_q  <= timeout_d;
            result_q   <= result_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        word_d     = word_q;
        last_d     = last_q;
        byte_d     = byte_q;
        boot_d     = boot_q;
        load_err_d = load_err_q;
        cycle_d    = cycle_q;
        pass_d     = pass_q;
        timeout_d  = timeout_q;
        result_d   = result_q;

        word_ready = 1'b0;
        mem_en     = 1'b0;
        mem_addr   = '0;
        mem_data   = '0;
        cpu_reset  = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            S_IDLE, S_FINISH: begin
                done = (state_q == S_FINISH);
                if (start) begin
                    state_d    = S_LOAD;
                    addr_d     = '0;
                    load_err_d = 1'b0;
                    cycle_d    = '0;
                    pass_d     = 1'b0;
                    timeout_d  = 1'b0;
                end
            end
            S_LOAD: begin
                busy       = 1'b1;
                word_ready = 1'b1;
                if (word_valid) begin
                    word_d  = word_data;
                    last_d  = word_last;
                    byte_d  = '0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                busy = 1'b1;
                // Out-of-range bytes are dropped but still advance the address.
                if (overflow) begin
                    load_err_d = 1'b1;
                end else begin
                    mem_en   = 1'b1;
                    mem_addr = addr_q;
                    mem_data = {24'b0, cur_byte};
                end
                addr_d = addr_q + 32'd1;
                byte_d = byte_q + 2'd1;
                if (byte_q == 2'd3) begin
                    state_d = last_q ? S_BOOT : S_LOAD;
                    boot_d  = 1'b0;
                end
            end
            S_BOOT: begin
                busy   = 1'b1;
                boot_d = 1'b1;
                if (boot_q) state_d = S_RUN;
            end
            S_RUN: begin
                busy      = 1'b1;
                cpu_reset = 1'b0;
                if (exit_hit) begin
                    state_d  = S_FINISH;
                    pass_d   = (gp == 32'd1) && (a0 == 32'd0);
                    result_d = gp;
                end else if (wdog_hit) begin
                    state_d   = S_FINISH;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                    result_d  = gp;
                end else begin
                    cycle_d = cycle_q + 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pass        = pass_q;
    assign timeout     = timeout_q;
    assign load_err    = load_err_q;
    assign result_code = result_q;
    assign cycle_count = cycle_q;

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// Self-checking bench for prog_loader_ctrl: directed sessions plus randomized programs
// compared against a byte-stream reference model of the memory image and run outcome.
module tb_prog_loader_ctrl;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TMO   = 50;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        word_valid;
    logic [31:0] word_data;
    logic        word_last;
    logic        word_ready;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        cpu_reset;
    logic [31:0] gp, a7, a0;
    logic        busy, done, pass, timeout, load_err;
    logic [31:0] result_code, cycle_count;

    prog_loader_ctrl #(.MEM_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset), .start(start),
        .word_valid(word_valid), .word_data(word_data), .word_last(word_last),
        .word_ready(word_ready),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_data(mem_data),
        .cpu_reset(cpu_reset), .gp(gp), .a7(a7), .a0(a0),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout), .load_err(load_err),
        .result_code(result_code), .cycle_count(cycle_count)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    logic [63:0] seen_q[$];
    logic [63:0] exp_q[$];
    bit          exp_err;
    int          last_wait;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
        if (mem_en === 1'b1) seen_q.push_back({mem_addr, mem_data});
    endtask

    // Expected memory image: consecutive little-endian bytes, dropped past DEPTH.
    task automatic model_load(input logic [31:0] prog[$]);
        int unsigned addr = 0;
        logic [31:0] w;
        exp_q.delete();
        exp_err = 1'b0;
        foreach (prog[i]) begin
            w = prog[i];
            for (int b = 0; b < 4; b++) begin
                if (addr < DEPTH) exp_q.push_back({32'(addr), (w >> (8 * b)) & 32'hFF});
                else exp_err = 1'b1;
                addr++;
            end
        end
    endtask

    task automatic begin_session();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("sess_busy", 32'(busy), 32'd1);
        check("sess_ready", 32'(word_ready), 32'd1);
        check("sess_done", 32'(done), 32'd0);
        check("sess_pass", 32'(pass), 32'd0);
        check("sess_timeout", 32'(timeout), 32'd0);
        check("sess_load_err", 32'(load_err), 32'd0);
        check("sess_cycles", cycle_count, 32'd0);
        seen_q.delete();
    endtask

    task automatic send_program(input logic [31:0] prog[$], input bit gaps);
        int budget;
        foreach (prog[i]) begin
            if (gaps) begin
                for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                    word_last = 1'($urandom);
                    tick();
                end
            end
            word_valid = 1'b1;
            word_data  = prog[i];
            word_last  = (i == prog.size() - 1);
            budget     = 0;
            while (word_ready !== 1'b1 && budget < 20) begin
                tick();
                budget++;
            end
            last_wait = budget;
            check("word_ready_wait", 32'(word_ready), 32'd1);
            tick();
            word_valid = 1'b0;
            word_last  = 1'($urandom);
            word_data  = $urandom;
        end
    endtask

    // Finishes the last word's bytes, checks the two BOOT cycles and RUN entry, then the image.
    task automatic load_and_boot(input logic [31:0] prog[$], input bit gaps);
        model_load(prog);
        send_program(prog, gaps);
        for (int i = 0; i < 3; i++) tick();
        for (int i = 0; i < 2; i++) begin
            tick();
            check("boot_cpu_reset", 32'(cpu_reset), 32'd1);
            check("boot_mem_en", 32'(mem_en), 32'd0);
            check("boot_busy", 32'(busy), 32'd1);
        end
        tick();
        check("run_cpu_reset", 32'(cpu_reset), 32'd0);
        check("run_cycles0", cycle_count, 32'd0);
        check("load_err", 32'(load_err), 32'(exp_err));
        check("write_count", 32'(seen_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++) begin
            check("write_addr", seen_q[i][63:32], exp_q[i][63:32]);
            check("write_data", seen_q[i][31:0], exp_q[i][31:0]);
        end
    endtask

    // Runs k cycles (start pulse ignored mid-run), then exits with the given taps.
    task automatic run_exit(input int k, input logic [31:0] gp_v, input logic [31:0] a0_v);
        a7 = 32'd0;
        for (int j = 0; j < k; j++) begin
            gp    = $urandom;
            a0    = $urandom;
            start = (j == 1);
            tick();
        end
        start = 1'b0;
        check("run_cycles", cycle_count, 32'(k));
        check("run_busy", 32'(busy), 32'd1);
        a7 = 32'd93;
        gp = gp_v;
        a0 = a0_v;
        tick();
        a7 = 32'd0;
        check("fin_done", 32'(done), 32'd1);
        check("fin_pass", 32'(pass), 32'((gp_v == 32'd1) && (a0_v == 32'd0)));
        check("fin_result", result_code, gp_v);
        check("fin_cycles", cycle_count, 32'(k));
        check("fin_cpu_reset", 32'(cpu_reset), 32'd1);
        check("fin_timeout", 32'(timeout), 32'd0);
        check("fin_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] prog[$];
        logic [31:0] g, z;

        reset = 1'b1; start = 1'b0; word_valid = 1'b0; word_data = '0; word_last = 1'b0;
        gp = '0; a7 = '0; a0 = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_ready", 32'(word_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_load_err", 32'(load_err), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_data", mem_data, 32'd0);
        check("rst_result", result_code, 32'd0);
        check("rst_cycles", cycle_count, 32'd0);

        // Directed load of two words, back-to-back, then a passing exit at cycle 10.
        begin_session();
        prog = '{32'h0000_0013, 32'h1234_5678};
        load_and_boot(prog, 1'b0);
        check("throughput_wait", 32'(last_wait), 32'd4);
        if (seen_q.size() == 8) begin
            check("byte4", seen_q[4], {32'd4, 32'h78});
            check("byte7", seen_q[7], {32'd7, 32'h12});
        end
        run_exit(10, 32'd1, 32'd0);

        // Restart from FINISH, failing exit.
        begin_session();
        prog = '{$urandom};
        load_and_boot(prog, 1'b1);
        run_exit(3, 32'd7, 32'd7);

        // Overflow: third word is consumed but never written.
        begin_session();
        prog = '{32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4};
        load_and_boot(prog, 1'b0);
        check("ovf_load_err", 32'(load_err), 32'd1);
        run_exit(0, 32'd1, 32'd0);

        // Randomized sessions.
        for (int s = 0; s < 10; s++) begin
            begin_session();
            prog.delete();
            for (int i = 0; i < int'($urandom_range(1, 3)); i++) prog.push_back($urandom);
            load_and_boot(prog, 1'b1);
            g = ($urandom_range(0, 1) == 1) ? 32'd1 : $urandom;
            z = ($urandom_range(0, 1) == 1) ? 32'd0 : $urandom;
            run_exit(int'($urandom_range(0, 40)), g, z);
        end

`ifdef PROG_LOADER_TIMEOUT_EN
        // Watchdog fires after TMO RUN cycles.
        begin_session();
        prog = '{$urandom};
        load_and_boot(prog, 1'b0);
        a7 = 32'd0;
        gp = 32'h55;
        a0 = 32'd0;
        for (int j = 0; j < TMO - 1; j++) tick();
        check("wd_not_yet", 32'(done), 32'd0);
        tick();
        check("wd_done", 32'(done), 32'd1);
        check("wd_timeout", 32'(timeout), 32'd1);
        check("wd_pass", 32'(pass), 32'd0);
        check("wd_result", result_code, 32'h55);
        // Exit on the last allowed cycle wins over the watchdog.
        begin_session();
        load_and_boot(prog, 1'b0);
        run_exit(TMO - 1, 32'd1, 32'd0);
`else
        // Without the watchdog RUN waits past TMO cycles.
        begin_session();
        prog = '{$urandom};
        load_and_boot(prog, 1'b0);
        a7 = 32'd0;
        for (int j = 0; j < TMO + 10; j++) tick();
        check("nowd_done", 32'(done), 32'd0);
        check("nowd_timeout", 32'(timeout), 32'd0);
        check("nowd_cycles", cycle_count, 32'(TMO + 10));
        a7 = 32'd93;
        tick();
        a7 = 32'd0;
        check("nowd_exit", 32'(done), 32'd1);
`endif

        // Reset during the second byte of WRITE abandons the word.
        begin_session();
        word_valid = 1'b1;
        word_data  = 32'hDEAD_BEEF;
        word_last  = 1'b1;
        tick();
        word_valid = 1'b0;
        tick();
        check("mid_byte1_en", 32'(mem_en), 32'd1);
        check("mid_byte1_addr", mem_addr, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_en", 32'(mem_en), 32'd0);
        check("mid_rst_cpu", 32'(cpu_reset), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        for (int j = 0; j < 4; j++) tick();
        check("mid_no_more_writes", 32'(seen_q.size()), 32'd2);
        begin_session();
        prog = '{32'h0403_0201, 32'h0807_0605};
        load_and_boot(prog, 1'b1);
        run_exit(5, 32'd1, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
